hs32_mem_arb: RTL and testbench

Two-port memory arbiter sitting directly upstream of `hs32_fetch` and the execute unit. It merges the fetch port's read-only instruction requests and the execute unit's load/store requests onto a single strobe/ack/stall memory bus. Every strobe accepted from a port is answered with exactly one `ack` or one `stl`. A stalled requester retries on its own. Execute has priority, with a starvation counter that guarantees fetch progress.

---
 rtl/hs32_mem_arb.sv | 138 +++++++++++++
 tb/tb_hs32_mem_arb.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/hs32_mem_arb.sv
// hs32_mem_arb: merges the fetch port (read-only) and the execute port
// (load/store) onto one strobe/ack/stall memory bus. Execute has priority;
// a saturating starvation counter hands contention to fetch once it has been
// rejected STARVE_LIMIT times since its last grant.
//
// state | meaning
// IDLE  | no transaction outstanding; a strobe is granted here
// BUSY  | memory owns a transaction for r_owner_e; waits for ack or stl
module hs32_mem_arb #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr_f,
  input  logic        stb_f,
  output logic [31:0] dtr_f,
  output logic        ack_f,
  output logic        stl_f,
  input  logic [31:0] addr_e,
  input  logic [31:0] dtw_e,
  input  logic        rw_e,
  input  logic        stb_e,
  output logic [31:0] dtr_e,
  output logic        ack_e,
  output logic        stl_e,
  output logic [31:0] addr,
  output logic [31:0] dtw,
  output logic        rw,
  output logic        stb,
  input  logic [31:0] dtr,
  input  logic        ack,
  input  logic        stl
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        r_state, w_state_nx;
  logic          r_owner_e, w_owner_e_nx;
  logic [31:0]   r_addr, w_addr_nx;
  logic [31:0]   r_dtw, w_dtw_nx;
  logic          r_rw, w_rw_nx;
  logic          r_stb, w_stb_nx;
  logic          r_stl_f, w_stl_f_nx;
  logic          r_stl_e, w_stl_e_nx;
  logic [SW-1:0] r_starve, w_starve_nx;
  logic          w_grant_f;
  logic          w_busy;

  // State and bus registers; reset abandons any outstanding transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_owner_e <= 1'b0;
      r_addr    <= '0;
      r_dtw     <= '0;
      r_rw      <= 1'b0;
      r_stb     <= 1'b0;
      r_stl_f   <= 1'b0;
      r_stl_e   <= 1'b0;
      r_starve  <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_owner_e <= w_owner_e_nx;
      r_addr    <= w_addr_nx;
      r_dtw     <= w_dtw_nx;
      r_rw      <= w_rw_nx;
      r_stb     <= w_stb_nx;
      r_stl_f   <= w_stl_f_nx;
      r_stl_e   <= w_stl_e_nx;
      r_starve  <= w_starve_nx;
    end
  end

  // Next-state: grant in IDLE, reject every strobe while BUSY, track starvation.
  always_comb begin
    w_state_nx   = r_state;
    w_owner_e_nx = r_owner_e;
    w_addr_nx    = r_addr;
    w_dtw_nx     = r_dtw;
    w_rw_nx      = r_rw;
    w_stb_nx     = 1'b0;
    w_stl_f_nx   = 1'b0;
    w_stl_e_nx   = 1'b0;
    w_grant_f    = 1'b0;
    case (r_state)
      IDLE: begin
        if (stb_e && !(stb_f && (r_starve == LIMIT))) begin
          w_state_nx   = BUSY;
          w_owner_e_nx = 1'b1;
          w_addr_nx    = addr_e;
          w_dtw_nx     = dtw_e;
          w_rw_nx      = rw_e;
          w_stb_nx     = 1'b1;
          w_stl_f_nx   = stb_f;
        end else if (stb_f) begin
          w_grant_f    = 1'b1;
          w_state_nx   = BUSY;
          w_owner_e_nx = 1'b0;
          w_addr_nx    = addr_f;
          w_dtw_nx     = '0;
          w_rw_nx      = 1'b0;
          w_stb_nx     = 1'b1;
          w_stl_e_nx   = stb_e;
        end
      end
      BUSY: begin
        w_stl_f_nx = stb_f;
        w_stl_e_nx = stb_e;
        if (ack || stl) w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
    // Only arbiter-issued fetch stalls count; forwarded memory stalls do not.
    w_starve_nx = r_starve;
    if (w_grant_f)
      w_starve_nx = '0;
    else if (w_stl_f_nx && (r_starve != LIMIT))
      w_starve_nx = r_starve + SW'(1);
  end

  assign w_busy = (r_state == BUSY);

  assign addr  = r_addr;
  assign dtw   = r_dtw;
  assign rw    = r_rw;
  assign stb   = r_stb;
  assign dtr_f = dtr;
  assign dtr_e = dtr;
  // ack wins over a simultaneous memory stall; responses in IDLE are dropped.
  assign ack_f = w_busy & ack & ~r_owner_e;
  assign ack_e = w_busy & ack & r_owner_e;
  assign stl_f = r_stl_f | (w_busy & stl & ~ack & ~r_owner_e);
  assign stl_e = r_stl_e | (w_busy & stl & ~ack & r_owner_e);

endmodule

// File: tb/tb_hs32_mem_arb.sv
// Directed bench for hs32_mem_arb with hand-computed expectations.
module tb_hs32_mem_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr_f, addr_e, dtw_e, dtr;
  logic        stb_f, stb_e, rw_e, ack, stl;
  logic [31:0] dtr_f, dtr_e, addr, dtw;
  logic        ack_f, stl_f, ack_e, stl_e, rw, stb;

  int n_checks = 0;
  int n_errors = 0;

  hs32_mem_arb #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .addr_f(addr_f), .stb_f(stb_f), .dtr_f(dtr_f), .ack_f(ack_f), .stl_f(stl_f),
    .addr_e(addr_e), .dtw_e(dtw_e), .rw_e(rw_e), .stb_e(stb_e),
    .dtr_e(dtr_e), .ack_e(ack_e), .stl_e(stl_e),
    .addr(addr), .dtw(dtw), .rw(rw), .stb(stb),
    .dtr(dtr), .ack(ack), .stl(stl)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; then inputs may change.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stb_f = 0; stb_e = 0; ack = 0; stl = 0;
  endtask

  task automatic do_reset();
    reset = 1; idle_inputs();
    step(); step();
    reset = 0;
  endtask

  initial begin
    addr_f = 0; addr_e = 0; dtw_e = 0; rw_e = 0; dtr = 0;
    do_reset();
    #1;
    chk("rst_stb", stb, 0);
    chk("rst_addr", addr, 0);
    chk("rst_dtw", dtw, 0);
    chk("rst_rw", rw, 0);
    chk("rst_ack_f", ack_f, 0);
    chk("rst_ack_e", ack_e, 0);
    chk("rst_stl_f", stl_f, 0);
    chk("rst_stl_e", stl_e, 0);
    chk("rst_starve", dut.r_starve, 0);

    // Single fetch read, ack at T0+3
    stb_f = 1; addr_f = 32'h100;
    step(); idle_inputs(); #1;
    chk("f1_stb", stb, 1);
    chk("f1_addr", addr, 32'h100);
    chk("f1_rw", rw, 0);
    chk("f1_dtw", dtw, 0);
    chk("f1_ack_f_early", ack_f, 0);
    chk("f1_ack_e", ack_e, 0);
    step(); #1;
    chk("f1_stb_once", stb, 0);
    chk("f1_addr_hold", addr, 32'h100);
    step(); ack = 1; dtr = 32'hDEADBEEF; #1;
    chk("f1_ack_f", ack_f, 1);
    chk("f1_dtr_f", dtr_f, 32'hDEADBEEF);
    chk("f1_ack_e_never", ack_e, 0);
    step(); idle_inputs(); #1;
    chk("f1_ack_f_gone", ack_f, 0);

    // Simultaneous strobes: execute wins (starve = 0)
    stb_f = 1; addr_f = 32'h200; stb_e = 1; addr_e = 32'h300; rw_e = 1; dtw_e = 32'h55;
    step(); idle_inputs(); #1;
    chk("sim_stl_f", stl_f, 1);
    chk("sim_stl_e", stl_e, 0);
    chk("sim_stb", stb, 1);
    chk("sim_addr", addr, 32'h300);
    chk("sim_rw", rw, 1);
    chk("sim_dtw", dtw, 32'h55);
    chk("sim_starve", dut.r_starve, 1);
    step(); ack = 1; #1;
    chk("sim_ack_e", ack_e, 1);
    chk("sim_ack_f", ack_f, 0);
    chk("sim_stl_f_once", stl_f, 0);
    step(); idle_inputs();

    // Strobe while busy
    stb_e = 1; addr_e = 32'h400; rw_e = 0; dtw_e = 32'h0;
    step(); stb_e = 0; stb_f = 1; addr_f = 32'h500; #1;
    chk("bz_stb", stb, 1);
    step(); idle_inputs(); #1;
    chk("bz_stl_f", stl_f, 1);
    chk("bz_addr", addr, 32'h400);
    chk("bz_stb_low", stb, 0);
    chk("bz_starve", dut.r_starve, 2);
    step(); ack = 1; dtr = 32'h1234; #1;
    chk("bz_stl_f_once", stl_f, 0);
    chk("bz_ack_e", ack_e, 1);
    chk("bz_dtr_e", dtr_e, 32'h1234);
    chk("bz_addr_ack", addr, 32'h400);
    step(); idle_inputs();

    // Starvation: four execute wins, fifth contention goes to fetch
    do_reset();
    for (int i = 0; i < 4; i++) begin
      stb_f = 1; addr_f = 32'hF00 + i; stb_e = 1; addr_e = 32'hE00 + i; rw_e = 0;
      step(); idle_inputs(); #1;
      chk("sv_stl_f", stl_f, 1);
      chk("sv_addr_e", addr, 32'hE00 + i);
      chk("sv_starve", dut.r_starve, i + 1);
      step(); ack = 1; #1;
      chk("sv_ack_e", ack_e, 1);
      step(); idle_inputs();
    end
    stb_f = 1; addr_f = 32'hF10; stb_e = 1; addr_e = 32'hE10; rw_e = 1; dtw_e = 32'h77;
    step(); idle_inputs(); #1;
    chk("sv5_stl_e", stl_e, 1);
    chk("sv5_stl_f", stl_f, 0);
    chk("sv5_addr", addr, 32'hF10);
    chk("sv5_rw", rw, 0);
    chk("sv5_dtw", dtw, 0);
    chk("sv5_starve", dut.r_starve, 0);
    step(); ack = 1; dtr = 32'hCAFE; #1;
    chk("sv5_ack_f", ack_f, 1);
    chk("sv5_dtr_f", dtr_f, 32'hCAFE);
    step(); idle_inputs();

    // Memory stall during a fetch
    stb_f = 1; addr_f = 32'h600;
    step(); idle_inputs();
    step(); stl = 1; #1;
    chk("ms_stl_f", stl_f, 1);
    chk("ms_ack_f", ack_f, 0);
    chk("ms_stl_e", stl_e, 0);
    step(); idle_inputs(); #1;
    chk("ms_stl_f_gone", stl_f, 0);
    chk("ms_starve", dut.r_starve, 0);
    stb_e = 1; addr_e = 32'h650; rw_e = 0;
    step(); idle_inputs(); #1;
    chk("ms_idle_grant", stb, 1);
    chk("ms_idle_stl_e", stl_e, 0);
    chk("ms_idle_addr", addr, 32'h650);
    // ack and stl together: ack wins
    step(); ack = 1; stl = 1; #1;
    chk("as_ack_e", ack_e, 1);
    chk("as_stl_e", stl_e, 0);
    step(); idle_inputs();

    // Late ack after reset abandons a fetch
    stb_f = 1; addr_f = 32'h700;
    step(); idle_inputs(); #1;
    chk("rb_stb", stb, 1);
    reset = 1;
    step(); reset = 0; ack = 1; dtr = 32'h9999; #1;
    chk("rb_stb", stb, 0);
    chk("rb_ack_f", ack_f, 0);
    chk("rb_stl_f", stl_f, 0);
    chk("rb_addr", addr, 0);
    step(); idle_inputs(); stl = 1; #1;
    chk("rb_late_stl", stl_f, 0);
    step(); idle_inputs();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
